// File: rtl/cpu_pkg.sv
// cpu_pkg: shared sizes and encodings for the audio sequencer core.
//   Sizes   : bus/line width, address width, immediate and instruction width,
//             and the number of instruction slots per line.
//   Types   : opcode_e (5-bit opcode field), dma_op_e (2-bit DMA command on
//             the op port), state_e (sequencer state).
package cpu_pkg;

    localparam int INW             = 512;
    localparam int ADDRW           = 32;
    localparam int DATAW           = 32;
    localparam int IMMW            = 11;
    localparam int INSTRW          = 16;
    localparam int OPCW            = INSTRW - IMMW;
    localparam int NUMINSTRUCTIONS = INW / INSTRW;
    localparam int PCW             = $clog2(NUMINSTRUCTIONS);

    typedef enum logic [OPCW-1:0] {
        OPC_NOP  = 5'h00,
        OPC_HALT = 5'h01,
        OPC_LDA  = 5'h02,
        OPC_ADDI = 5'h03,
        OPC_RD   = 5'h04,
        OPC_WR   = 5'h05,
        OPC_PLAY = 5'h06,
        OPC_SETF = 5'h07,
        OPC_SETV = 5'h08,
        OPC_SYN  = 5'h09,
        OPC_JMP  = 5'h0A,
        OPC_LCNT = 5'h0B,
        OPC_DJNZ = 5'h0C
    } opcode_e;

    typedef enum logic [1:0] {
        DMA_IDLE  = 2'b00,
        DMA_READ  = 2'b01,
        DMA_WRITE = 2'b10
    } dma_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_WAIT_REQ,
        ST_WAIT_RD,
        ST_WAIT_WR,
        ST_WAIT_PLAY,
        ST_HALT
    } state_e;

endpackage

// File: rtl/cpu_imem.sv
// cpu_imem: 32 x 16-bit instruction store.
//   clk     : clock
//   rst     : synchronous active-high reset, clears every slot to NOP
//   load_en : capture a whole line; slot i takes line_in[16i+15:16i]
//   line_in : instruction line from the common data bus
//   rd_addr : program counter
//   rd_data : instruction at rd_addr (combinational read)
module cpu_imem
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [INW-1:0]    line_in,
    input  logic [PCW-1:0]    rd_addr,
    output logic [INSTRW-1:0] rd_data
);

    logic [INSTRW-1:0] mem_q [NUMINSTRUCTIONS];

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: this store is built from flops rather than a RAM macro, so it
            // can be reset; clearing it means a run before any load executes NOPs.
            for (int i = 0; i < NUMINSTRUCTIONS; i++) begin
                mem_q[i] <= {OPC_NOP, {IMMW{1'b0}}};
            end
        end else if (load_en) begin
            for (int i = 0; i < NUMINSTRUCTIONS; i++) begin
                mem_q[i] <= line_in[i*INSTRW +: INSTRW];
            end
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/cpu.sv
// cpu: in-order sequencer core for the audio synthesizer.
//   clk                : clock, all state updates on the rising edge
//   rst_n              : synchronous reset, ACTIVE-HIGH despite its name
//   tx_done            : DMA write transfer complete
//   rd_valid           : audio consumer accepted audio_out
//   dma_ready          : DMA accepts the request presented on op
//   instr_write_en     : load common_data_bus_in as the instruction line
//   mem_write_en       : load common_data_bus_in into the audio line buffer
//   common_data_bus_in : shared 512-bit bus
//   cache_stall        : core is waiting on a DMA operation
//   syn / set_en       : one-cycle synth trigger / parameter write strobes
//   set_freq           : with set_en, 1 = frequency, 0 = volume
//   audio_valid        : audio_out holds a line for the consumer
//   imm                : immediate of the last syn/set_en strobe
//   audio_out          : audio line buffer
//   mem_address        : address register
//   op                 : DMA command (00 idle, 01 read, 10 write)
module cpu
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tx_done,
    input  logic             rd_valid,
    input  logic             dma_ready,
    input  logic             instr_write_en,
    input  logic             mem_write_en,
    input  logic [INW-1:0]   common_data_bus_in,
    output logic             cache_stall,
    output logic             syn,
    output logic             set_en,
    output logic             set_freq,
    output logic             audio_valid,
    output logic [IMMW-1:0]  imm,
    output logic [INW-1:0]   audio_out,
    output logic [ADDRW-1:0] mem_address,
    output logic [1:0]       op
);

    state_e            state_q, state_d;
    logic [PCW-1:0]    pc_q, pc_d, pc_inc;
    logic [DATAW-1:0]  addr_q, addr_d;
    logic [IMMW-1:0]   cnt_q, cnt_d, cnt_dec;
    logic [IMMW-1:0]   imm_q, imm_d;
    dma_op_e           op_q, op_d;
    logic              stall_q, stall_d;
    logic              syn_q, syn_d;
    logic              set_en_q, set_en_d;
    logic              set_freq_q, set_freq_d;
    logic              av_q, av_d;
    logic [INW-1:0]    audio_q;

    logic [INSTRW-1:0] instr;
    logic [OPCW-1:0]   opc;
    logic [IMMW-1:0]   ifield;

    cpu_imem u_imem (
        .clk     (clk),
        .rst     (rst_n),
        .load_en (instr_write_en),
        .line_in (common_data_bus_in),
        .rd_addr (pc_q),
        .rd_data (instr)
    );

    assign opc     = instr[INSTRW-1:IMMW];
    assign ifield  = instr[IMMW-1:0];
    assign pc_inc  = pc_q + PCW'(1);
    assign cnt_dec = cnt_q - IMMW'(1);

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can
        // leave one unassigned and infer a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        stall_d    = stall_q;
        syn_d      = 1'b0;
        set_en_d   = 1'b0;
        set_freq_d = set_freq_q;
        imm_d      = imm_q;
        av_d       = av_q;

        if (instr_write_en) begin
            // A new line aborts whatever was in flight and restarts at slot 0.
            state_d = ST_RUN;
            pc_d    = '0;
            op_d    = DMA_IDLE;
            stall_d = 1'b0;
            av_d    = 1'b0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    pc_d = pc_inc;
                    case (opc)
                        OPC_HALT: begin
                            state_d = ST_HALT;
                            pc_d    = pc_q;
                        end
                        OPC_LDA:  addr_d = {{(DATAW-IMMW){1'b0}}, ifield};
                        OPC_ADDI: addr_d = addr_q + {{(DATAW-IMMW){ifield[IMMW-1]}}, ifield};
                        // Blocking instructions hold the PC; it advances when the wait ends.
                        OPC_RD: begin
                            op_d    = DMA_READ;
                            stall_d = 1'b1;
                            state_d = ST_WAIT_REQ;
                            pc_d    = pc_q;
                        end
                        OPC_WR: begin
                            op_d    = DMA_WRITE;
                            stall_d = 1'b1;
                            state_d = ST_WAIT_REQ;
                            pc_d    = pc_q;
                        end
                        OPC_PLAY: begin
                            av_d    = 1'b1;
                            state_d = ST_WAIT_PLAY;
                            pc_d    = pc_q;
                        end
                        OPC_SETF: begin
                            set_en_d   = 1'b1;
                            set_freq_d = 1'b1;
                            imm_d      = ifield;
                        end
                        OPC_SETV: begin
                            set_en_d   = 1'b1;
                            set_freq_d = 1'b0;
                            imm_d      = ifield;
                        end
                        OPC_SYN: begin
                            syn_d = 1'b1;
                            imm_d = ifield;
                        end
                        OPC_JMP:  pc_d = ifield[PCW-1:0];
                        OPC_LCNT: cnt_d = ifield;
                        OPC_DJNZ: begin
                            // A counter already at zero stays there and falls through.
                            if (cnt_q != '0) begin
                                cnt_d = cnt_dec;
                                if (cnt_dec != '0) pc_d = ifield[PCW-1:0];
                            end
                        end
                        default: ;
                    endcase
                end
                ST_WAIT_REQ: begin
                    if (dma_ready) begin
                        op_d    = DMA_IDLE;
                        state_d = (op_q == DMA_READ) ? ST_WAIT_RD : ST_WAIT_WR;
                    end
                end
                ST_WAIT_RD: begin
                    // The returning line arrives on the bus with mem_write_en.
                    if (mem_write_en) begin
                        stall_d = 1'b0;
                        pc_d    = pc_inc;
                        state_d = ST_RUN;
                    end
                end
                ST_WAIT_WR: begin
                    if (tx_done) begin
                        stall_d = 1'b0;
                        pc_d    = pc_inc;
                        state_d = ST_RUN;
                    end
                end
                ST_WAIT_PLAY: begin
                    if (rd_valid) begin
                        av_d    = 1'b0;
                        pc_d    = pc_inc;
                        state_d = ST_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registers update with non-blocking assignments so every flop
        // samples the values from before this edge.
        if (rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            op_q       <= DMA_IDLE;
            stall_q    <= 1'b0;
            syn_q      <= 1'b0;
            set_en_q   <= 1'b0;
            set_freq_q <= 1'b0;
            imm_q      <= '0;
            av_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            stall_q    <= stall_d;
            syn_q      <= syn_d;
            set_en_q   <= set_en_d;
            set_freq_q <= set_freq_d;
            imm_q      <= imm_d;
            av_q       <= av_d;
        end
    end

    // The audio buffer is captured in every state, independent of execution.
    always_ff @(posedge clk) begin
        if (rst_n)             audio_q <= '0;
        else if (mem_write_en) audio_q <= common_data_bus_in;
    end

    assign cache_stall = stall_q;
    assign syn         = syn_q;
    assign set_en      = set_en_q;
    assign set_freq    = set_freq_q;
    assign audio_valid = av_q;
    assign imm         = imm_q;
    assign audio_out   = audio_q;
    assign mem_address = ADDRW'(addr_q);
    assign op          = op_q;

endmodule

// File: tb/tb_cpu.sv
// tb_cpu: directed scenarios plus randomized handshakes and programs, with a
// behavioural model of the sequencer checked against the DUT every cycle.
module tb_cpu;

    localparam int NOP = 0, HALT = 1, LDA = 2, ADDI = 3, RD = 4, WR = 5, PLAY = 6,
                   SETF = 7, SETV = 8, SYN = 9, JMP = 10, LCNT = 11, DJNZ = 12;

    localparam int M_IDLE = 0, M_RUN = 1, M_REQ = 2, M_RD = 3, M_WR = 4, M_PLAY = 5, M_HALT = 6;

    logic         clk = 1'b0;
    logic         rst_n, tx_done, rd_valid, dma_ready, instr_write_en, mem_write_en;
    logic [511:0] bus;
    logic         cache_stall, syn, set_en, set_freq, audio_valid;
    logic [10:0]  imm;
    logic [511:0] audio_out;
    logic [31:0]  mem_address;
    logic [1:0]   op;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;
    int syn_cnt = 0;
    int set_cnt = 0;

    // Behavioural model state and expected outputs.
    logic [15:0]  m_mem [32];
    int           m_pc, m_mode, m_cnt;
    bit           m_pend_rd;
    logic [31:0]  m_addr;
    bit           e_stall, e_syn, e_set_en, e_set_freq, e_av;
    logic [10:0]  e_imm;
    logic [511:0] e_audio;
    logic [1:0]   e_op;

    logic [511:0] line;

    cpu dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .tx_done            (tx_done),
        .rd_valid           (rd_valid),
        .dma_ready          (dma_ready),
        .instr_write_en     (instr_write_en),
        .mem_write_en       (mem_write_en),
        .common_data_bus_in (bus),
        .cache_stall        (cache_stall),
        .syn                (syn),
        .set_en             (set_en),
        .set_freq           (set_freq),
        .audio_valid        (audio_valid),
        .imm                (imm),
        .audio_out          (audio_out),
        .mem_address        (mem_address),
        .op                 (op)
    );

    initial forever #5 clk = ~clk;

    // ---------------- behavioural model, stepped on every rising edge -------------
    task automatic model_step();
        logic [15:0] ins;
        int opc, f, nxt;
        if (rst_n) begin
            for (int i = 0; i < 32; i++) m_mem[i] = 16'h0000;
            m_pc = 0; m_mode = M_IDLE; m_cnt = 0; m_addr = '0; m_pend_rd = 1'b0;
            e_stall = 0; e_syn = 0; e_set_en = 0; e_set_freq = 0; e_av = 0;
            e_imm = '0; e_audio = '0; e_op = 2'b00;
            return;
        end
        ins = m_mem[m_pc];
        opc = int'(ins[15:11]);
        f   = int'(ins[10:0]);
        nxt = (m_pc + 1) % 32;
        e_syn = 0;
        e_set_en = 0;
        if (mem_write_en) e_audio = bus;
        if (instr_write_en) begin
            for (int i = 0; i < 32; i++) m_mem[i] = bus[16*i +: 16];
            m_pc = 0; m_mode = M_RUN; e_op = 2'b00; e_stall = 0; e_av = 0;
        end else begin
            case (m_mode)
                M_RUN: begin
                    m_pc = nxt;
                    case (opc)
                        HALT: begin m_mode = M_HALT; m_pc = (nxt + 31) % 32; end
                        LDA:  m_addr = 32'(f);
                        ADDI: m_addr = m_addr + 32'((f >= 1024) ? f - 2048 : f);
                        RD:   begin e_op = 2'b01; e_stall = 1; m_pend_rd = 1; m_mode = M_REQ; end
                        WR:   begin e_op = 2'b10; e_stall = 1; m_pend_rd = 0; m_mode = M_REQ; end
                        PLAY: begin e_av = 1; m_mode = M_PLAY; end
                        SETF: begin e_set_en = 1; e_set_freq = 1; e_imm = 11'(f); end
                        SETV: begin e_set_en = 1; e_set_freq = 0; e_imm = 11'(f); end
                        SYN:  begin e_syn = 1; e_imm = 11'(f); end
                        JMP:  m_pc = f % 32;
                        LCNT: m_cnt = f;
                        DJNZ: if (m_cnt != 0) begin
                                  m_cnt = m_cnt - 1;
                                  if (m_cnt != 0) m_pc = f % 32;
                              end
                        default: ;
                    endcase
                    // Waiting instructions advance the PC only when the wait ends.
                    if (m_mode == M_REQ || m_mode == M_PLAY) m_pc = (nxt + 31) % 32;
                end
                M_REQ: if (dma_ready) begin e_op = 2'b00; m_mode = m_pend_rd ? M_RD : M_WR; end
                M_RD:  if (mem_write_en) begin e_stall = 0; m_pc = nxt; m_mode = M_RUN; end
                M_WR:  if (tx_done) begin e_stall = 0; m_pc = nxt; m_mode = M_RUN; end
                M_PLAY: if (rd_valid) begin e_av = 0; m_pc = nxt; m_mode = M_RUN; end
                default: ;
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- per-cycle compare against the model -------------------------
    initial forever begin
        @(negedge clk);
        if (syn === 1'b1) syn_cnt++;
        if (set_en === 1'b1) set_cnt++;
        if (chk_en) begin
            vectors++;
            if ({cache_stall, syn, set_en, set_freq, audio_valid, imm, mem_address, op, audio_out} !==
                {e_stall, e_syn, e_set_en, e_set_freq, e_av, e_imm, m_addr, e_op, e_audio}) begin
                miscompares++;
                $display("FAIL cycle t=%0t (actual/required) stall=%b/%b syn=%b/%b set_en=%b/%b set_freq=%b/%b av=%b/%b imm=%h/%h addr=%h/%h op=%b/%b audio=%h/%h",
                         $time, cache_stall, e_stall, syn, e_syn, set_en, e_set_en, set_freq, e_set_freq,
                         audio_valid, e_av, imm, e_imm, mem_address, m_addr, op, e_op, audio_out, e_audio);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic put(input int slot, input int opc, input int f);
        line[16*slot +: 16] = {5'(opc), 11'(f)};
    endtask

    task automatic load_line();
        bus = line;
        instr_write_en = 1'b1;
        tick();
        instr_write_en = 1'b0;
    endtask

    task automatic rand_bus();
        for (int i = 0; i < 16; i++) bus[32*i +: 32] = $urandom;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        rst_n = 1'b1; tx_done = 0; rd_valid = 0; dma_ready = 0;
        instr_write_en = 0; mem_write_en = 0; bus = '0;

        // Reset for two cycles.
        tick();
        chk_en = 1'b1;
        tick();
        check("reset_stall", 512'(cache_stall), 512'(0));
        check("reset_op", 512'(op), 512'(0));
        check("reset_syn", 512'(syn), 512'(0));
        check("reset_audio_valid", 512'(audio_valid), 512'(0));
        rst_n = 1'b0;
        idle(2);

        // SYN 0x005 then HALT: one strobe only.
        base = syn_cnt;
        line = '0; put(0, SYN, 5); put(1, HALT, 0);
        load_line();
        idle(6);
        check("syn_pulses", 512'(syn_cnt - base), 512'(1));
        check("syn_imm", 512'(imm), 512'(11'h005));

        // LDA 0x100; ADDI -1; WR; HALT.
        line = '0; put(0, LDA, 11'h100); put(1, ADDI, 11'h7FF); put(2, WR, 0); put(3, HALT, 0);
        load_line();
        idle(5);
        check("wr_op_held", 512'(op), 512'(2'b10));
        check("wr_stall", 512'(cache_stall), 512'(1));
        check("wr_addr", 512'(mem_address), 512'(32'h0FF));
        check("model_addr", 512'(m_addr), 512'(32'h0FF));
        dma_ready = 1; tick(); dma_ready = 0;
        tick();
        check("wr_op_after_ready", 512'(op), 512'(0));
        check("wr_stall_waiting", 512'(cache_stall), 512'(1));
        tx_done = 1; tick(); tx_done = 0;
        check("wr_stall_released", 512'(cache_stall), 512'(0));
        idle(3);

        // RD; PLAY; HALT with a late dma_ready and an A5 line returned.
        line = '0; put(0, RD, 0); put(1, PLAY, 0); put(2, HALT, 0);
        load_line();
        tick();
        check("rd_op", 512'(op), 512'(2'b01));
        tick();
        dma_ready = 1; tick(); dma_ready = 0;
        check("rd_op_dropped", 512'(op), 512'(0));
        idle(2);
        check("rd_stall_waiting", 512'(cache_stall), 512'(1));
        bus = {64{8'hA5}}; mem_write_en = 1; tick(); mem_write_en = 0;
        check("rd_stall_released", 512'(cache_stall), 512'(0));
        check("rd_audio", audio_out, {64{8'hA5}});
        check("model_audio", e_audio, {64{8'hA5}});
        idle(3);
        check("play_valid", 512'(audio_valid), 512'(1));
        rd_valid = 1; tick(); rd_valid = 0;
        check("play_valid_dropped", 512'(audio_valid), 512'(0));
        idle(2);

        // LCNT 3; SETF 0x040; DJNZ 1; HALT: three frequency writes.
        base = set_cnt;
        line = '0; put(0, LCNT, 3); put(1, SETF, 11'h040); put(2, DJNZ, 1); put(3, HALT, 0);
        load_line();
        idle(15);
        check("djnz_set_pulses", 512'(set_cnt - base), 512'(3));
        check("djnz_set_freq", 512'(set_freq), 512'(1));
        check("djnz_imm", 512'(imm), 512'(11'h040));

        // Abort a pending read with a new line.
        line = '0; put(0, RD, 0); put(1, HALT, 0);
        load_line();
        idle(2);
        dma_ready = 1; tick(); dma_ready = 0;
        idle(2);
        line = '0; put(0, SYN, 7); put(1, HALT, 0);
        load_line();
        check("abort_op", 512'(op), 512'(0));
        check("abort_stall", 512'(cache_stall), 512'(0));
        idle(3);
        check("abort_restart_imm", 512'(imm), 512'(11'h007));

        // Reset in the middle of a running loop.
        line = '0; put(0, SETV, 3); put(1, JMP, 0);
        load_line();
        idle(3);
        rst_n = 1'b1; tick(); rst_n = 1'b0;
        check("midreset_audio", audio_out, 512'(0));
        check("midreset_addr", 512'(mem_address), 512'(0));
        check("midreset_imm", 512'(imm), 512'(0));
        check("midreset_set_freq", 512'(set_freq), 512'(0));
        idle(2);

        // JMP 31 onto an empty slot wraps the PC back to slot 0.
        line = '0; put(0, SYN, 1); put(1, JMP, 31);
        load_line();
        base = syn_cnt;
        idle(12);
        check("wrap_syn_pulses", 512'(syn_cnt - base), 512'(4));

        // Randomized programs and handshakes.
        line = '0;
        for (int i = 0; i < 32; i++) put(i, $urandom_range(0, 15), $urandom_range(0, 2047));
        load_line();
        for (int c = 0; c < 3000; c++) begin
            rst_n          = ($urandom_range(0, 399) == 0);
            dma_ready      = ($urandom_range(0, 1) == 0);
            tx_done        = ($urandom_range(0, 2) == 0);
            rd_valid       = ($urandom_range(0, 2) == 0);
            mem_write_en   = ($urandom_range(0, 7) == 0);
            instr_write_en = ($urandom_range(0, 39) == 0);
            if (instr_write_en) begin
                for (int i = 0; i < 32; i++) put(i, $urandom_range(0, 15), $urandom_range(0, 2047));
                bus = line;
            end else begin
                rand_bus();
            end
            tick();
        end
        rst_n = 0; dma_ready = 0; tx_done = 0; rd_valid = 0; mem_write_en = 0; instr_write_en = 0;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cpu.md
Name: cpu

Overview:
- Small sequencer core for the audio synthesizer.
- Holds one 512-bit line of 16-bit instructions loaded from the common data bus, plus one 512-bit audio line buffer.
- Executes the program in order and issues DMA read/write requests, synthesizer control strobes and audio-line output.
- Sits between the host/DMA bus interface and the synth/audio back end.

Parameters:
- INW, 512, width of common data bus, instruction line and audio line.
- ADDRW, 32, width of the memory address register.
- DATAW, 32, internal data width (address arithmetic).
- IMMW, 11, immediate field width.
- INSTRW, 16, instruction width.
- NUMINSTRUCTIONS, INW/INSTRW (32), instruction slots per line; PC width is clog2 of this.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-high (asserted when 1).
- tx_done  in  1  DMA write transfer complete.
- rd_valid  in  1  audio consumer accepted audio_out.
- dma_ready  in  1  DMA accepts the request on op.
- instr_write_en  in  1  load common_data_bus_in into instruction memory.
- mem_write_en  in  1  load common_data_bus_in into the audio line buffer.
- common_data_bus_in  in  INW  shared 512-bit bus.
- cache_stall  out  1  core stalled on a DMA operation.
- syn  out  1  synth trigger strobe.
- set_en  out  1  synth parameter write strobe.
- set_freq  out  1  with set_en: 1 = frequency, 0 = volume.
- audio_valid  out  1  audio_out holds a line for the consumer.
- imm  out  IMMW  immediate accompanying syn/set_en.
- audio_out  out  INW  audio line buffer contents, always driven.
- mem_address  out  ADDRW  address register, always driven.
- op  out  2  DMA command: 00 idle, 01 read, 10 write, 11 reserved/never driven.

Behaviour:
- Reset: all outputs 0, PC=0, address register 0, loop counter 0, instruction memory cleared to NOP, audio buffer 0, state IDLE.
- Priority per cycle: reset > instr_write_en > execution.
- Instruction slot i = bus bits [16i+15:16i]; PC order is slot 0 first. Encoding: opcode [15:11], imm [10:0].
- instr_write_en: capture line, PC<=0, op<=0, clear stalls, state RUN from next cycle; permitted at any time, aborting current work.
- mem_write_en: capture bus into the audio buffer in any state; same-cycle with instr_write_en, both captured.
- RUN executes one instruction per cycle. PC+1 wraps 31→0. Strobes (syn, set_en) are high exactly one cycle.
- Opcodes (undefined opcodes behave as NOP):
  - 00 NOP.
  - 01 HALT: state HALT, exited only by instr_write_en or reset.
  - 02 LDA: addr<=zero-extended imm.
  - 03 ADDI: addr<=addr+sign-extended imm, mod 2^32.
  - 04 RD: op<=01, cache_stall<=1, state WAIT_REQ(RD).
  - 05 WR: op<=10, cache_stall<=1, state WAIT_REQ(WR).
  - 06 PLAY: audio_valid<=1, state WAIT_PLAY.
  - 07 SETF: set_en=1, set_freq=1, imm=imm.
  - 08 SETV: set_en=1, set_freq=0, imm=imm.
  - 09 SYN: syn=1, imm=imm.
  - 0A JMP: PC<=imm[4:0].
  - 0B LCNT: counter<=imm.
  - 0C DJNZ: counter<=counter-1; if result≠0, PC<=imm[4:0], else PC+1; counter at 0 stays 0 and falls through.
- imm output holds its last value between strobes.
- WAIT_REQ: hold op until dma_ready=1, then op<=00 and go to WAIT_RD or WAIT_WR.
- WAIT_RD: leave on mem_write_en (line captured that cycle); cache_stall<=0, PC+1, RUN.
- WAIT_WR: leave on tx_done; cache_stall<=0, PC+1, RUN.
- WAIT_PLAY: hold audio_valid until rd_valid=1, then audio_valid<=0, PC+1, RUN.
- cache_stall is 1 throughout WAIT_REQ, WAIT_RD and WAIT_WR.
- In RUN, PC advances by 1 for all non-branch instructions. Branches to an empty (NOP) slot are legal.

Decomposition:
- Package cpu_pkg: opcode enum (5 bits), DMA op enum (2 bits), state enum (IDLE, RUN, WAIT_REQ, WAIT_RD, WAIT_WR, WAIT_PLAY, HALT).
- One sub-module cpu_imem: 32x16 instruction store with line load and PC read port.
- Everything else stays in the top module.

Test Plan:
- Reset=1 for 2 cycles → all outputs 0, op=00, cache_stall=0. Load line {SYN 0x005, HALT} → syn high exactly 1 cycle, imm=0x005, then stays halted with no further strobes.
- Program LDA 0x100; ADDI 0x7FF(−1); WR; HALT → mem_address=0x100 then 0x0FF; op=10 until dma_ready; cache_stall held until tx_done pulse; then HALT.
- Program RD; PLAY; HALT with dma_ready after 3 cycles → op=01 for 3 cycles; a mem_write_en with bus=0xA5…A5 releases the stall; audio_out=0xA5…A5 and audio_valid=1 until rd_valid, then 0.
- Program LCNT 3; SETF 0x040; DJNZ 1; HALT → exactly 3 set_en pulses, set_freq=1, imm=0x040; PC ends at slot 3.
- Mid-WAIT_RD, assert instr_write_en with a new line → op=00, cache_stall=0 next cycle, execution restarts at slot 0. Reset mid-run → all outputs 0.
- JMP 31 to a NOP slot → PC wraps to 0 and re-executes the program.
